// File: rtl/branch_resolve_unit_if.sv
// EXE-side bundle of the branch resolve unit: EXE/prediction inputs in, predictor
// update bus, front-end redirect and performance counters out.
interface branch_resolve_unit_if #(parameter int SIZE_OF_INDEX = 8);
    logic                     exe_valid;
    logic                     exe_wr;
    logic                     exe_flush;
    logic [31:0]              exe_pc;
    logic [2:0]               exe_type;
    logic                     exe_taken;
    logic [31:0]              exe_target;
    logic                     pred_valid;
    logic                     pred_hit;
    logic                     pred_taken;
    logic [31:0]              pred_target;
    logic [1:0]               pred_count;
    logic [SIZE_OF_INDEX-1:0] pred_index;
    logic                     id_ds_valid;

    logic                     bres_valid;
    logic [31:0]              bres_pc;
    logic [31:0]              bres_target;
    logic [2:0]               bres_type;
    logic                     bres_taken;
    logic                     bres_hit;
    logic [1:0]               bres_count;
    logic [SIZE_OF_INDEX-1:0] bres_index;
    logic                     redirect_valid;
    logic [31:0]              redirect_pc;
    logic                     if_flush;
    logic                     wait_ds;
    logic [31:0]              branch_cnt;
    logic [31:0]              mispred_cnt;

    modport master (
        output exe_valid, exe_wr, exe_flush, exe_pc, exe_type, exe_taken, exe_target,
               pred_valid, pred_hit, pred_taken, pred_target, pred_count, pred_index,
               id_ds_valid,
        input  bres_valid, bres_pc, bres_target, bres_type, bres_taken, bres_hit,
               bres_count, bres_index, redirect_valid, redirect_pc, if_flush, wait_ds,
               branch_cnt, mispred_cnt
    );

    modport slave (
        input  exe_valid, exe_wr, exe_flush, exe_pc, exe_type, exe_taken, exe_target,
               pred_valid, pred_hit, pred_taken, pred_target, pred_count, pred_index,
               id_ds_valid,
        output bres_valid, bres_pc, bres_target, bres_type, bres_taken, bres_hit,
               bres_count, bres_index, redirect_valid, redirect_pc, if_flush, wait_ds,
               branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// EXE-stage branch resolution: compares outcome with the IF prediction, feeds the
// predictor update bus and sequences the front-end redirect around the delay slot.
module branch_resolve_unit #(
    parameter int SIZE_OF_INDEX = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_resolve_unit_if.slave  bru
);
    localparam logic [2:0] BIS_NONE = 3'd0;

    typedef enum logic {IDLE, WAIT_DS} state_e;

    state_e      state_q;
    logic        reported_q;
    logic        wait_ds_q;
    logic [31:0] ds_pc_q;
    logic [31:0] branch_cnt_q;
    logic [31:0] mispred_cnt_q;

    logic        resolve;
    logic        taken_p;
    logic        mispred;
    logic [31:0] correct_pc;
    logic        redir;
    logic [31:0] redir_pc;
    logic [SIZE_OF_INDEX-1:0] index_w;

    // reported_q blocks a second update while the same branch sits stalled in EXE
    assign resolve    = bru.exe_valid & ~bru.exe_flush & (bru.exe_type != BIS_NONE) & ~reported_q;
    assign taken_p    = bru.pred_valid & bru.pred_taken;
    assign mispred    = resolve & ((bru.exe_taken != taken_p) |
                                   (bru.exe_taken & (bru.pred_target != bru.exe_target)));
    assign correct_pc = bru.exe_taken ? bru.exe_target : bru.exe_pc + 32'd8;
    assign index_w    = bru.pred_index;

    // A resolve seen while waiting for the slot is not allowed to redirect
    always_comb begin
        redir    = 1'b0;
        redir_pc = '0;
        if (!rst && !bru.exe_flush && bru.id_ds_valid) begin
            if (state_q == IDLE && mispred) begin
                redir    = 1'b1;
                redir_pc = correct_pc;
            end else if (state_q == WAIT_DS) begin
                redir    = 1'b1;
                redir_pc = ds_pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            reported_q    <= 1'b0;
            wait_ds_q     <= 1'b0;
            ds_pc_q       <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (bru.exe_wr || bru.exe_flush) reported_q <= 1'b0;
            else if (resolve)                reported_q <= 1'b1;

            if (resolve) branch_cnt_q  <= branch_cnt_q + 32'd1;
            if (mispred) mispred_cnt_q <= mispred_cnt_q + 32'd1;

            case (state_q)
                IDLE: begin
                    if (mispred && !bru.id_ds_valid) begin
                        state_q   <= WAIT_DS;
                        wait_ds_q <= 1'b1;
                        ds_pc_q   <= correct_pc;
                    end
                end
                WAIT_DS: begin
                    if (bru.exe_flush || bru.id_ds_valid) begin
                        state_q   <= IDLE;
                        wait_ds_q <= 1'b0;
                        ds_pc_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bru.bres_valid     = resolve & ~rst;
    assign bru.bres_pc        = rst ? '0 : bru.exe_pc;
    assign bru.bres_target    = rst ? '0 : bru.exe_target;
    assign bru.bres_type      = rst ? '0 : bru.exe_type;
    assign bru.bres_taken     = ~rst & bru.exe_taken;
    assign bru.bres_hit       = ~rst & bru.pred_hit;
    assign bru.bres_count     = rst ? '0 : bru.pred_count;
    assign bru.bres_index     = rst ? '0 : index_w;
    assign bru.redirect_valid = redir;
    assign bru.redirect_pc    = redir_pc;
    assign bru.if_flush       = redir;
    assign bru.wait_ds        = ~rst & wait_ds_q;
    assign bru.branch_cnt     = rst ? '0 : branch_cnt_q;
    assign bru.mispred_cnt    = rst ? '0 : mispred_cnt_q;
endmodule
